femto8_bus_responder: RTL

Memory and I/O responder on the far end of the femto8 CPU bus: it answers every CPU address with read data and accepts CPU stores. It holds 128 bytes of RAM, a 128-byte program ROM that can be loaded through a side port, and a small memory-mapped I/O window. The I/O window has a buffered output port, a single-byte input mailbox and a free-running timer. It sits between the CPU bus pins and the top-level test harness, replacing ad-hoc RAM/ROM arrays.

---
 rtl/femto8_bus_responder.sv | 139 +++++++++++++
 1 files changed

// File: rtl/femto8_bus_responder.sv
// femto8 bus responder: 128 B RAM, side-loadable 128 B ROM, and an I/O window
// with a buffered output FIFO, a one-byte input mailbox and a free-running timer.
module femto8_bus_responder #(
    parameter int FIFO_DEPTH = 4,
    parameter int TIMER_DIV  = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] address,
    input  logic [7:0] data_from_cpu,
    input  logic       write,
    output logic [7:0] data_to_cpu,
    input  logic       rom_load_valid,
    input  logic [6:0] rom_load_addr,
    input  logic [7:0] rom_load_data,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam int PRE_W = (TIMER_DIV > 1) ? $clog2(TIMER_DIV) : 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TIMER_DIV - 1);

    localparam logic [7:0] ADDR_OUT    = 8'h0C;
    localparam logic [7:0] ADDR_MBOX   = 8'h0D;
    localparam logic [7:0] ADDR_STATUS = 8'h0E;
    localparam logic [7:0] ADDR_TIMER  = 8'h0F;

    logic [7:0] ram [128];
    logic [7:0] rom [128];
    logic [7:0] fifo_mem [FIFO_DEPTH];

    logic [PTR_W-1:0] rd_ptr, wr_ptr;
    logic [CNT_W-1:0] count;
    logic             overflow;
    logic             in_full;
    logic [7:0]       mailbox;
    logic [7:0]       timer;
    logic [PRE_W-1:0] prescaler;

    logic out_full, out_empty;
    logic push_req, push, pop, tick, timer_load, status_wr, ram_wr;
    logic [3:0] count4;
    logic [7:0] status;

    assign out_full   = (count == FULL_CNT);
    assign out_empty  = (count == '0);
    assign out_valid  = ~out_empty;
    assign out_data   = fifo_mem[rd_ptr];
    assign in_ready   = ~in_full;

    assign pop        = out_valid & out_ready;
    assign push_req   = write & (address == ADDR_OUT);
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign push       = push_req & (~out_full | pop);
    assign status_wr  = write & (address == ADDR_STATUS);
    assign timer_load = write & (address == ADDR_TIMER);
    assign ram_wr     = write & ~address[7] & (address[6:2] != 5'b00011);
    assign tick       = (prescaler == PRE_LAST);

    assign count4 = 4'(count);
    assign status = {in_full, out_full, out_empty, overflow, count4};

    always_comb begin
        data_to_cpu = ram[address[6:0]];
        if (address[7]) begin
            data_to_cpu = rom[address[6:0]];
        end else begin
            case (address)
                ADDR_OUT:    data_to_cpu = 8'h00;
                ADDR_MBOX:   data_to_cpu = mailbox;
                ADDR_STATUS: data_to_cpu = status;
                ADDR_TIMER:  data_to_cpu = timer;
                default:     data_to_cpu = ram[address[6:0]];
            endcase
        end
    end

    // Storage arrays are never cleared; ROM loads are honoured even during reset.
    always_ff @(posedge clk) begin
        if (rom_load_valid) rom[rom_load_addr] <= rom_load_data;
        if (ram_wr)         ram[address[6:0]]  <= data_from_cpu;
        if (push)           fifo_mem[wr_ptr]   <= data_from_cpu;
        if (in_valid && !in_full) mailbox      <= in_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (push_req && !push)
                overflow <= 1'b1;
            else if (status_wr && data_from_cpu[1])
                overflow <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            in_full <= 1'b0;
        end else if (in_valid && !in_full) begin
            in_full <= 1'b1;
        end else if (status_wr && data_from_cpu[0]) begin
            in_full <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            timer     <= '0;
            prescaler <= '0;
        end else if (timer_load) begin
            timer     <= data_from_cpu;
            prescaler <= '0;
        end else if (tick) begin
            timer     <= timer + 1'b1;
            prescaler <= '0;
        end else begin
            prescaler <= prescaler + 1'b1;
        end
    end

endmodule
